// File: rtl/nbit_seq_alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, FSM state type and mode width for
//               the sequential N-bit ALU.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package alu_pkg;

  localparam int MODE_W = 4;

  localparam logic [MODE_W-1:0] OP_ADD = 4'd0;
  localparam logic [MODE_W-1:0] OP_SUB = 4'd1;
  localparam logic [MODE_W-1:0] OP_AND = 4'd2;
  localparam logic [MODE_W-1:0] OP_OR  = 4'd3;
  localparam logic [MODE_W-1:0] OP_XOR = 4'd4;
  localparam logic [MODE_W-1:0] OP_NOT = 4'd5;
  localparam logic [MODE_W-1:0] OP_INC = 4'd6;
  localparam logic [MODE_W-1:0] OP_DEC = 4'd7;
  localparam logic [MODE_W-1:0] OP_MUL = 4'd8;
  localparam logic [MODE_W-1:0] OP_SHL = 4'd9;
  localparam logic [MODE_W-1:0] OP_SHR = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/nbit_seq_alu_if.sv
// ============================================================================
// Module      : nbit_seq_alu_if
// Description : Operand/result bundle of the sequential ALU. The master side
//               issues operations, the slave side (the ALU) returns results.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface nbit_seq_alu_if #(
  parameter int N = 4
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      A;
  logic [N-1:0]      B;
  logic              CB_in;
  logic [MODE_W-1:0] Mode;
  logic              out_valid;
  logic [N-1:0]      Result;
  logic [N-1:0]      Result_hi;
  logic              CB_out;
  logic              zero;
  logic              neg;
  logic              ovf;
  logic              illegal;

  modport master (
    output in_valid, A, B, CB_in, Mode,
    input  in_ready, out_valid, Result, Result_hi, CB_out, zero, neg, ovf, illegal
  );

  modport slave (
    input  in_valid, A, B, CB_in, Mode,
    output in_ready, out_valid, Result, Result_hi, CB_out, zero, neg, ovf, illegal
  );

endinterface

`default_nettype wire

// File: rtl/nbit_seq_alu_mult.sv
// ============================================================================
// Module      : seq_mult_unit
// Description : Iterative unsigned shift-add multiplier, one multiplier bit
//               per clock. Bit 0 is folded into the load cycle so the full
//               product is ready N-1 edges after start; done pulses then.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module seq_mult_unit #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]   mcand_q;
  logic [2*N-1:0] prod_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;

  logic [2*N-1:0] w_src;
  logic [N-1:0]   w_mc;
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_next;

  // One shift-add step: conditionally add the multiplicand into the high half,
  // then shift the whole accumulator right (multiplier bits drain from the low half).
  always_comb begin
    w_src  = start ? {{N{1'b0}}, b} : prod_q;
    w_mc   = start ? a : mcand_q;
    w_sum  = {1'b0, w_src[2*N-1:N]} + (w_src[0] ? {1'b0, w_mc} : {(N+1){1'b0}});
    w_next = {w_sum, w_src[N-1:1]};
  end

  // Iteration counter, accumulator and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand_q <= a;
        prod_q  <= w_next;
        cnt_q   <= CW'(1);
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        prod_q <= w_next;
        cnt_q  <= cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

`default_nettype wire

// File: rtl/nbit_seq_alu.sv
// ============================================================================
// Module      : nbit_seq_alu
// Description : Registered N-bit ALU with valid/ready input, status flags and
//               a multi-cycle multiplier. Single-cycle ops register their
//               result on the accepting edge; MUL blocks input for N cycles.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module nbit_seq_alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  nbit_seq_alu_if.slave   bus
);

  state_t         state_q, state_d;
  logic           w_accept;
  logic           w_mul_start;
  logic           w_sc_load;
  logic           w_mul_load;
  logic           mult_busy;
  logic           mult_done;
  logic [2*N-1:0] mult_prod;

  logic [N:0]     w_sum, w_dif, w_inc, w_dec;
  logic [N-1:0]   w_res;
  logic           w_cb, w_ovf, w_ill;

  logic           out_valid_q;
  logic [N-1:0]   result_q, result_hi_q;
  logic           cb_out_q, zero_q, neg_q, ovf_q, illegal_q;

  assign bus.in_ready = (state_q == ST_IDLE);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_sc_load    = w_accept && (bus.Mode != OP_MUL);
  assign w_mul_load   = (state_q == ST_MUL_RUN) && mult_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and multiplier launch; MUL_RUN ends when the multiplier goes idle.
  always_comb begin
    state_d     = state_q;
    w_mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept && (bus.Mode == OP_MUL)) begin
          w_mul_start = 1'b1;
          state_d     = ST_MUL_RUN;
        end
      end
      ST_MUL_RUN: begin
        if (!mult_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  seq_mult_unit #(.N(N)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_prod)
  );

  // Single-cycle datapath: all arithmetic at N+1 bits so the top bit is carry/borrow.
  always_comb begin
    w_sum = {1'b0, bus.A} + {1'b0, bus.B} + {{N{1'b0}}, bus.CB_in};
    w_dif = {1'b0, bus.A} - {1'b0, bus.B} - {{N{1'b0}}, bus.CB_in};
    w_inc = {1'b0, bus.A} + {{N{1'b0}}, 1'b1};
    w_dec = {1'b0, bus.A} - {{N{1'b0}}, 1'b1};
    w_res = '0;
    w_cb  = 1'b0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (bus.Mode)
      OP_ADD: begin
        w_res = w_sum[N-1:0];
        w_cb  = w_sum[N];
        w_ovf = (bus.A[N-1] == bus.B[N-1]) && (w_sum[N-1] != bus.A[N-1]);
      end
      OP_SUB: begin
        w_res = w_dif[N-1:0];
        w_cb  = w_dif[N];
        w_ovf = (bus.A[N-1] != bus.B[N-1]) && (w_dif[N-1] != bus.A[N-1]);
      end
      OP_AND: w_res = bus.A & bus.B;
      OP_OR:  w_res = bus.A | bus.B;
      OP_XOR: w_res = bus.A ^ bus.B;
      OP_NOT: w_res = ~bus.A;
      OP_INC: begin
        w_res = w_inc[N-1:0];
        w_cb  = w_inc[N];
      end
      OP_DEC: begin
        w_res = w_dec[N-1:0];
        w_cb  = w_dec[N];
      end
      OP_MUL: ;
      OP_SHL: begin
        w_res = {bus.A[N-2:0], bus.CB_in};
        w_cb  = bus.A[N-1];
      end
      OP_SHR: begin
        w_res = {bus.CB_in, bus.A[N-1:1]};
        w_cb  = bus.A[0];
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Output registers: hold between updates; zero/neg follow the value registered into Result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      cb_out_q    <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (w_sc_load) begin
        out_valid_q <= 1'b1;
        result_q    <= w_res;
        result_hi_q <= '0;
        cb_out_q    <= w_cb;
        zero_q      <= (w_res == '0);
        neg_q       <= w_res[N-1];
        ovf_q       <= w_ovf;
        illegal_q   <= w_ill;
      end else if (w_mul_load) begin
        out_valid_q <= 1'b1;
        result_q    <= mult_prod[N-1:0];
        result_hi_q <= mult_prod[2*N-1:N];
        cb_out_q    <= (mult_prod[2*N-1:N] != '0);
        zero_q      <= (mult_prod[N-1:0] == '0);
        neg_q       <= mult_prod[N-1];
        ovf_q       <= 1'b0;
        illegal_q   <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Result_hi = result_hi_q;
  assign bus.CB_out    = cb_out_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_nbit_seq_alu.sv
// ============================================================================
// Module      : tb_nbit_seq_alu
// Description : Directed self-checking bench for nbit_seq_alu at N=4.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nbit_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  nbit_seq_alu_if #(.N(4)) bus ();

  nbit_seq_alu #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] res,
                            input logic [3:0] hi, input logic cb, input logic z,
                            input logic ng, input logic o, input logic il);
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    check({tag, ".Result"},    {28'd0, bus.Result},    {28'd0, res});
    check({tag, ".Result_hi"}, {28'd0, bus.Result_hi}, {28'd0, hi});
    check({tag, ".CB_out"},    {31'd0, bus.CB_out},    {31'd0, cb});
    check({tag, ".zero"},      {31'd0, bus.zero},      {31'd0, z});
    check({tag, ".neg"},       {31'd0, bus.neg},       {31'd0, ng});
    check({tag, ".ovf"},       {31'd0, bus.ovf},       {31'd0, o});
    check({tag, ".illegal"},   {31'd0, bus.illegal},   {31'd0, il});
  endtask

  // Present an operation at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic apply(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b, input logic cb);
    bus.Mode     = m;
    bus.A        = a;
    bus.B        = b;
    bus.CB_in    = cb;
    bus.in_valid = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.CB_in    = 1'b0;
    bus.Mode     = '0;
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // ADD with carry out
    apply(OP_ADD, 4'hF, 4'h1, 1'b1);
    bus.in_valid = 1'b0;
    expect_out("add_carry", 1, 4'h1, 4'h0, 1, 0, 0, 0, 0);
    @(negedge clk);

    // ADD signed overflow, then SUB back-to-back
    apply(OP_ADD, 4'h7, 4'h1, 1'b0);
    expect_out("add_ovf", 1, 4'h8, 4'h0, 0, 0, 1, 1, 0);
    apply(OP_SUB, 4'h3, 4'h5, 1'b0);
    bus.in_valid = 1'b0;
    expect_out("sub_borrow", 1, 4'hE, 4'h0, 1, 0, 1, 0, 0);
    @(negedge clk);
    check("hold.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("hold.Result", {28'd0, bus.Result}, 32'hE);

    // Logic ops streamed back-to-back
    apply(OP_AND, 4'hC, 4'hA, 1'b0);
    expect_out("and", 1, 4'h8, 4'h0, 0, 0, 1, 0, 0);
    apply(OP_OR, 4'h5, 4'hA, 1'b1);
    expect_out("or", 1, 4'hF, 4'h0, 0, 0, 1, 0, 0);
    apply(OP_XOR, 4'hF, 4'h5, 1'b0);
    expect_out("xor", 1, 4'hA, 4'h0, 0, 0, 1, 0, 0);
    apply(OP_NOT, 4'h3, 4'h0, 1'b0);
    bus.in_valid = 1'b0;
    expect_out("not", 1, 4'hC, 4'h0, 0, 0, 1, 0, 0);
    @(negedge clk);

    // MUL F*F = E1; an in_valid pulse during the run must be ignored
    apply(OP_MUL, 4'hF, 4'hF, 1'b1);
    bus.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("mul_run%0d.in_ready", j), {31'd0, bus.in_ready}, 32'd0);
      check($sformatf("mul_run%0d.out_valid", j), {31'd0, bus.out_valid}, 32'd0);
      bus.Mode     = OP_ADD;
      bus.A        = 4'h1;
      bus.B        = 4'h1;
      bus.in_valid = (j == 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    expect_out("mul", 1, 4'h1, 4'hE, 1, 0, 0, 0, 0);
    check("mul_done.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    check("mul_after.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mul_after.Result", {28'd0, bus.Result}, 32'h1);

    // INC/DEC wrap, shifts through carry, ADD of two negatives
    apply(OP_INC, 4'hF, 4'h0, 1'b0);
    expect_out("inc_wrap", 1, 4'h0, 4'h0, 1, 1, 0, 0, 0);
    apply(OP_DEC, 4'h0, 4'h0, 1'b0);
    expect_out("dec_wrap", 1, 4'hF, 4'h0, 1, 0, 1, 0, 0);
    apply(OP_SHL, 4'h9, 4'h0, 1'b1);
    expect_out("shl", 1, 4'h3, 4'h0, 1, 0, 0, 0, 0);
    apply(OP_SHR, 4'h9, 4'h0, 1'b0);
    expect_out("shr", 1, 4'h4, 4'h0, 1, 0, 0, 0, 0);
    apply(OP_ADD, 4'h9, 4'h9, 1'b0);
    bus.in_valid = 1'b0;
    expect_out("add_negovf", 1, 4'h2, 4'h0, 1, 0, 0, 1, 0);
    @(negedge clk);

    // Illegal opcode, then a legal op clears the flag
    apply(4'd12, 4'h5, 4'h3, 1'b1);
    expect_out("illegal", 1, 4'h0, 4'h0, 0, 1, 0, 0, 1);
    apply(OP_AND, 4'hC, 4'hA, 1'b0);
    bus.in_valid = 1'b0;
    expect_out("legal_after", 1, 4'h8, 4'h0, 0, 0, 1, 0, 0);
    @(negedge clk);

    // Reset in the middle of a MUL aborts it
    apply(OP_MUL, 4'h3, 4'h5, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_out("mul_abort", 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    check("mul_abort.in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d.out_valid", j), {31'd0, bus.out_valid}, 32'd0);
      check($sformatf("abort_quiet%0d.in_ready", j), {31'd0, bus.in_ready}, 32'd1);
    end
    apply(OP_ADD, 4'h2, 4'h3, 1'b0);
    bus.in_valid = 1'b0;
    expect_out("add_after_rst", 1, 4'h5, 4'h0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
